// File: rtl/sense_trace_ctrl_pkg.sv
// Shared definitions for the carry-chain delay-line sensor trace sequencer:
// state encoding, default line length and the count-width derivation.
package sense_trace_ctrl_pkg;

    localparam int          LINELEN_DEFAULT = 64;
    localparam logic [15:0] SAT_MAX         = 16'hFFFF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WARMUP,
        ST_CAPTURE,
        ST_DRAIN
    } state_e;

    // Width needed to hold a population count in the range 0..linelen.
    function automatic int cntw(input int linelen);
        return $clog2(linelen + 1);
    endfunction

endpackage

// File: rtl/sense_fifo.sv
// Synchronous show-ahead FIFO: the head entry is always visible on rdata_o.
// A write into an empty FIFO becomes visible only after the write edge.
module sense_fifo #(
    parameter int WIDTH = 7,
    parameter int DEPTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wrPtr_q, wrPtr_d;
    logic [AW:0]      rdPtr_q, rdPtr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             doWrite;
    logic             doRead;

    // The extra pointer bit distinguishes full from empty when the indices match.
    assign empty_o = (wrPtr_q == rdPtr_q);
    assign full_o  = (wrPtr_q[AW] != rdPtr_q[AW]) && (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
    assign doRead  = pop_i && !empty_o;
    assign doWrite = push_i && (!full_o || doRead);
    assign wrPtr_d = doWrite ? wrPtr_q + (AW+1)'(1) : wrPtr_q;
    assign rdPtr_d = doRead  ? rdPtr_q + (AW+1)'(1) : rdPtr_q;
    assign rdata_o = mem_q[rdPtr_q[AW-1:0]];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (doWrite) begin
            mem_q[wrPtr_q[AW-1:0]] <= wdata_i;
        end
    end

endmodule

// File: rtl/sense_trace_ctrl.sv
// Trace sequencer for the delay-line voltage sensor: warm-up, fixed-length
// capture, popcount reduction, FIFO buffering and saturation statistics.
module sense_trace_ctrl
    import sense_trace_ctrl_pkg::*;
#(
    parameter int LINELEN    = LINELEN_DEFAULT,
    parameter int CNTW       = cntw(LINELEN),
    parameter int WARMUP     = 16,
    parameter int NSAMPLES   = 256,
    parameter int FIFO_DEPTH = 16
) (
    input  logic               clkin,
    input  logic               rstnin,
    input  logic               trigin,
    input  logic [LINELEN-1:0] valin,
    output logic               enaout,
    output logic [CNTW-1:0]    dataout,
    output logic               validout,
    input  logic               readyin,
    output logic               busyout,
    output logic               doneout,
    output logic               ovfout,
    output logic [15:0]        satlowout,
    output logic [15:0]        sathighout
);

    localparam int SEQ_MAX = (WARMUP > NSAMPLES) ? WARMUP : NSAMPLES;
    localparam int SEQ_W   = $clog2(SEQ_MAX + 1);

    function automatic logic [CNTW-1:0] popcount(input logic [LINELEN-1:0] v);
        logic [CNTW-1:0] c;
        c = '0;
        for (int i = 0; i < LINELEN; i++) begin
            c = c + CNTW'(v[i]);
        end
        return c;
    endfunction

    state_e             state_q, state_d;
    logic [SEQ_W-1:0]   seqCnt_q, seqCnt_d;
    logic [LINELEN-1:0] st1Data_q;
    logic               st1Valid_q;
    logic               ovf_q, ovf_d;
    logic [15:0]        satLow_q, satLow_d;
    logic [15:0]        satHigh_q, satHigh_d;
    logic               done_q, done_d;
    logic               runStart;
    logic [CNTW-1:0]    sampleCnt;
    logic [CNTW-1:0]    fifoData;
    logic               fifoFull;
    logic               fifoEmpty;
    logic               fifoPop;
    logic               dropSample;

    assign sampleCnt  = popcount(st1Data_q);
    assign fifoPop    = readyin && !fifoEmpty;
    assign dropSample = st1Valid_q && fifoFull && !fifoPop;

    // One counter is shared between the warm-up window and the sample index.
    always_comb begin
        state_d  = state_q;
        seqCnt_d = seqCnt_q;
        done_d   = 1'b0;
        runStart = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (trigin) begin
                    state_d  = ST_WARMUP;
                    seqCnt_d = '0;
                    runStart = 1'b1;
                end
            end
            ST_WARMUP: begin
                if (seqCnt_q == SEQ_W'(WARMUP - 1)) begin
                    state_d  = ST_CAPTURE;
                    seqCnt_d = '0;
                end else begin
                    seqCnt_d = seqCnt_q + SEQ_W'(1);
                end
            end
            ST_CAPTURE: begin
                if (seqCnt_q == SEQ_W'(NSAMPLES - 1)) begin
                    state_d = ST_DRAIN;
                end else begin
                    seqCnt_d = seqCnt_q + SEQ_W'(1);
                end
            end
            ST_DRAIN: begin
                if (!st1Valid_q && fifoEmpty) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Statistics see every stage-2 sample, including those the FIFO drops.
    always_comb begin
        ovf_d     = ovf_q;
        satLow_d  = satLow_q;
        satHigh_d = satHigh_q;
        if (runStart) begin
            ovf_d     = 1'b0;
            satLow_d  = '0;
            satHigh_d = '0;
        end else if (st1Valid_q) begin
            if (dropSample) begin
                ovf_d = 1'b1;
            end
            if (sampleCnt == '0 && satLow_q != SAT_MAX) begin
                satLow_d = satLow_q + 16'd1;
            end
            if (sampleCnt == CNTW'(LINELEN) && satHigh_q != SAT_MAX) begin
                satHigh_d = satHigh_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clkin or negedge rstnin) begin
        if (!rstnin) begin
            state_q    <= ST_IDLE;
            seqCnt_q   <= '0;
            st1Data_q  <= '0;
            st1Valid_q <= 1'b0;
            ovf_q      <= 1'b0;
            satLow_q   <= '0;
            satHigh_q  <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            seqCnt_q   <= seqCnt_d;
            st1Valid_q <= (state_q == ST_CAPTURE);
            if (state_q == ST_CAPTURE) begin
                st1Data_q <= valin;
            end
            ovf_q      <= ovf_d;
            satLow_q   <= satLow_d;
            satHigh_q  <= satHigh_d;
            done_q     <= done_d;
        end
    end

    sense_fifo #(
        .WIDTH(CNTW),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk_i  (clkin),
        .rst_ni (rstnin),
        .push_i (st1Valid_q),
        .wdata_i(sampleCnt),
        .pop_i  (fifoPop),
        .rdata_o(fifoData),
        .full_o (fifoFull),
        .empty_o(fifoEmpty)
    );

    assign enaout     = (state_q == ST_WARMUP) || (state_q == ST_CAPTURE);
    assign busyout    = (state_q != ST_IDLE);
    assign doneout    = done_q;
    assign validout   = !fifoEmpty;
    assign dataout    = fifoEmpty ? '0 : fifoData;
    assign ovfout     = ovf_q;
    assign satlowout  = satLow_q;
    assign sathighout = satHigh_q;

endmodule

// File: tb/tb_sense_trace_ctrl.sv
// Self-checking bench for sense_trace_ctrl: timeline table, directed corner
// sequences and randomized traffic against a queue-based reference model.
module tb_sense_trace_ctrl;

    localparam int LL = 64;
    localparam int CW = 7;
    localparam int W  = 4;
    localparam int N  = 20;
    localparam int D  = 16;
    localparam int TBL_LEN = W + N + 6;
    localparam logic [LL-1:0] HALF = 64'h0000_0000_FFFF_FFFF;
    localparam logic [LL-1:0] ALL1 = {LL{1'b1}};
    localparam logic [LL-1:0] ALL0 = {LL{1'b0}};

    typedef struct {
        logic          trig;
        logic [LL-1:0] val;
        logic          rdy;
        logic          ena;
        logic          valid;
        logic          busy;
        logic          done;
        logic [CW-1:0] data;
    } vec_t;

    logic          clkin   = 1'b0;
    logic          rstnin  = 1'b1;
    logic          trigin  = 1'b0;
    logic          readyin = 1'b0;
    logic [LL-1:0] valin   = '0;
    logic          enaout, validout, busyout, doneout, ovfout;
    logic [CW-1:0] dataout;
    logic [15:0]   satlowout, sathighout;

    int nChecks = 0;
    int nPass   = 0;
    int cycle   = 0;

    // Reference model: run phase measured in edges since trigger acceptance.
    bit            mBusy, mPend, mOvf, mDone;
    int            mT, mLow, mHigh;
    logic [LL-1:0] mPendVal;
    int            q[$];

    vec_t tbl [TBL_LEN];
    int   drained;
    bit   sawDone;
    int   got[$];
    logic rdyR;

    sense_trace_ctrl #(
        .LINELEN(LL), .CNTW(CW), .WARMUP(W), .NSAMPLES(N), .FIFO_DEPTH(D)
    ) dut (
        .clkin(clkin), .rstnin(rstnin), .trigin(trigin), .valin(valin),
        .enaout(enaout), .dataout(dataout), .validout(validout), .readyin(readyin),
        .busyout(busyout), .doneout(doneout), .ovfout(ovfout),
        .satlowout(satlowout), .sathighout(sathighout)
    );

    always #5 clkin = ~clkin;

    function automatic logic [LL-1:0] randWord();
        int sel = $urandom_range(0, 7);
        if (sel == 0) return ALL0;
        if (sel == 1) return ALL1;
        return {$urandom, $urandom};
    endfunction

    function automatic logic [LL-1:0] onesMask(input int n);
        logic [LL-1:0] m = '0;
        for (int i = 0; i < LL; i++) if (i < n) m[i] = 1'b1;
        return m;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act === exp) nPass++;
        else $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cycle, act, exp);
    endtask

    task automatic checkModel();
        checkOutput("enaout",     enaout,     mBusy && (mT < W + N));
        checkOutput("busyout",    busyout,    mBusy);
        checkOutput("doneout",    doneout,    mDone);
        checkOutput("validout",   validout,   q.size() > 0);
        checkOutput("dataout",    dataout,    (q.size() > 0) ? 64'(q[0]) : 64'd0);
        checkOutput("ovfout",     ovfout,     mOvf);
        checkOutput("satlowout",  satlowout,  64'(mLow));
        checkOutput("sathighout", sathighout, 64'(mHigh));
    endtask

    task automatic applyStimulus(input logic trig, input logic [LL-1:0] val, input logic rdy);
        bit pendBefore;
        int qBefore;
        int c;
        trigin  = trig;
        valin   = val;
        readyin = rdy;
        @(posedge clkin);
        cycle++;
        pendBefore = mPend;
        qBefore    = q.size();
        if (rdy && qBefore > 0) void'(q.pop_front());
        if (mPend) begin
            c = $countones(mPendVal);
            if (c == 0 && mLow < 65535) mLow++;
            if (c == LL && mHigh < 65535) mHigh++;
            if (q.size() == D) mOvf = 1'b1;
            else q.push_back(c);
        end
        mPend = 1'b0;
        mDone = 1'b0;
        if (mBusy) begin
            if (mT >= W + N && !pendBefore && qBefore == 0) begin
                mBusy = 1'b0;
                mDone = 1'b1;
            end else begin
                mT++;
                if (mT >= W + 1 && mT <= W + N) begin
                    mPend    = 1'b1;
                    mPendVal = val;
                end
            end
        end else if (trig) begin
            mBusy = 1'b1;
            mT    = 0;
            mOvf  = 1'b0;
            mLow  = 0;
            mHigh = 0;
        end
        #1;
        checkModel();
    endtask

    task automatic doReset();
        rstnin  = 1'b0;
        trigin  = 1'b0;
        readyin = 1'b0;
        valin   = '0;
        mBusy = 1'b0; mPend = 1'b0; mOvf = 1'b0; mDone = 1'b0;
        mT = 0; mLow = 0; mHigh = 0;
        q.delete();
        #1;
        checkModel();
        @(posedge clkin);
        #1;
        checkModel();
        rstnin = 1'b1;
    endtask

    task automatic waitIdle();
        for (int k = 0; k < 200 && (busyout || validout); k++) applyStimulus(1'b0, randWord(), 1'b1);
        checkOutput("idleTimeout", busyout, 1'b0);
    endtask

    initial begin
        #2;
        doReset();

        // Nominal run timeline: half-populated word, consumer always ready.
        for (int k = 0; k < TBL_LEN; k++) begin
            tbl[k].trig  = (k == 0);
            tbl[k].val   = HALF;
            tbl[k].rdy   = 1'b1;
            tbl[k].ena   = (k < W + N);
            tbl[k].valid = (k >= W + 2) && (k <= W + N + 1);
            tbl[k].data  = tbl[k].valid ? CW'(32) : CW'(0);
            tbl[k].busy  = (k < W + N + 3);
            tbl[k].done  = (k == W + N + 3);
        end
        for (int k = 0; k < TBL_LEN; k++) begin
            applyStimulus(tbl[k].trig, tbl[k].val, tbl[k].rdy);
            checkOutput($sformatf("tbl%0d.ena", k),   enaout,   tbl[k].ena);
            checkOutput($sformatf("tbl%0d.valid", k), validout, tbl[k].valid);
            checkOutput($sformatf("tbl%0d.data", k),  dataout,  tbl[k].data);
            checkOutput($sformatf("tbl%0d.busy", k),  busyout,  tbl[k].busy);
            checkOutput($sformatf("tbl%0d.done", k),  doneout,  tbl[k].done);
        end

        // Alternating empty / full lines saturate both statistics equally.
        applyStimulus(1'b1, ALL0, 1'b1);
        for (int k = 1; k < W + N + 4; k++) applyStimulus(1'b0, (k % 2) ? ALL1 : ALL0, 1'b1);
        checkOutput("altDone", doneout, 1'b1);
        checkOutput("altLow", satlowout, 10);
        checkOutput("altHigh", sathighout, 10);
        checkOutput("altOvf", ovfout, 1'b0);

        // Stalled consumer: FIFO fills, later samples drop, then exactly D drain.
        applyStimulus(1'b1, randWord(), 1'b0);
        for (int k = 1; k < W + N + 6; k++) applyStimulus(1'b0, randWord(), 1'b0);
        checkOutput("stallOvf", ovfout, 1'b1);
        checkOutput("stallValid", validout, 1'b1);
        checkOutput("stallBusy", busyout, 1'b1);
        drained = 0;
        sawDone = 1'b0;
        for (int k = 0; k < 60 && !sawDone; k++) begin
            if (validout) drained++;
            applyStimulus(1'b0, randWord(), 1'b1);
            if (doneout) sawDone = 1'b1;
        end
        checkOutput("drainCount", drained, D);
        checkOutput("drainDone", sawDone, 1'b1);

        // Trigger held high: one run, the next accepted right after doneout.
        sawDone = 1'b0;
        for (int k = 0; k < W + N + 10 && !sawDone; k++) begin
            applyStimulus(1'b1, ALL1, 1'b1);
            if (doneout) sawDone = 1'b1;
        end
        checkOutput("heldDone", sawDone, 1'b1);
        checkOutput("heldHigh", sathighout, N);
        checkOutput("heldLow", satlowout, 0);
        applyStimulus(1'b1, ALL1, 1'b1);
        checkOutput("rerunBusy", busyout, 1'b1);
        checkOutput("rerunEna", enaout, 1'b1);
        checkOutput("rerunClear", sathighout, 0);
        waitIdle();

        // Push into a full FIFO in the same cycle as a pop: nothing is lost.
        got.delete();
        sawDone = 1'b0;
        for (int k = 0; k < 100 && !sawDone; k++) begin
            rdyR = (k >= W + 18);
            if (validout && rdyR) got.push_back(int'(dataout));
            applyStimulus(k == 0, onesMask(k > W ? k - W : 0), rdyR);
            if (doneout) sawDone = 1'b1;
        end
        checkOutput("fullPopDone", sawDone, 1'b1);
        checkOutput("fullPopCount", got.size(), N);
        checkOutput("fullPopOvf", ovfout, 1'b0);
        for (int i = 0; i < got.size(); i++) checkOutput($sformatf("fullPopOrder%0d", i), got[i], i + 1);

        // Asynchronous reset mid-capture with five counts buffered.
        for (int k = 0; k <= W + 6; k++) applyStimulus(k == 0, randWord(), 1'b0);
        checkOutput("fiveValid", validout, 1'b1);
        checkOutput("fiveEna", enaout, 1'b1);
        doReset();
        applyStimulus(1'b0, ALL0, 1'b1);
        checkOutput("postResetValid", validout, 1'b0);
        checkOutput("postResetBusy", busyout, 1'b0);

        // Randomized traffic in three consumer-readiness regimes.
        for (int mode = 0; mode < 3; mode++) begin
            for (int k = 0; k < 300; k++) begin
                if (mode == 0) rdyR = 1'b1;
                else if (mode == 1) rdyR = ($urandom_range(0, 1) == 0);
                else rdyR = ($urandom_range(0, 4) == 0);
                applyStimulus($urandom_range(0, 9) == 0, randWord(), rdyR);
            end
            waitIdle();
        end

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
